// File: rtl/sha256_msg_packer.sv
// sha256_msg_packer: frames UART bytes (length byte L, then L bytes), applies
// SHA-256 padding and streams one 512-bit block as sixteen big-endian 32-bit
// words into the core (MP_dv_out / message_out).
// Optional build macro: RX_TIMEOUT_EN adds an inter-byte gap timeout in S_COLLECT.
module sha256_msg_packer #(
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_LEN        = 55,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_dv_in,
    input  logic [7:0]            rx_byte_in,
    input  logic                  core_ready_in,
    output logic                  MP_dv_out,
    output logic [DATA_WIDTH-1:0] message_out,
    output logic                  busy_out,
    output logic                  err_out
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WAIT_CORE, S_SEND} state_t;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t      state;
    logic [5:0]  len_q;
    logic [5:0]  byte_cnt;
    logic [3:0]  word_cnt;
    logic [7:0]  msg_buf [0:63];

    logic [3:0]  word_sel;
    logic [8:0]  bit_len;
    logic [5:0]  idx;
    logic [7:0]  byte_v;
    logic [31:0] word_nxt;

`ifdef RX_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
    logic [GAP_W-1:0] gap_cnt;
`endif

    assign busy_out = (state != S_IDLE);

    // Build the padded word that goes out on the next edge: word 0 when
    // launching from S_WAIT_CORE, otherwise the word after the current one.
    always_comb begin
        word_sel = (state == S_SEND) ? word_cnt + 4'd1 : 4'd0;
        bit_len  = {len_q, 3'b000};
        idx      = '0;
        byte_v   = '0;
        word_nxt = '0;
        for (int j = 0; j < 4; j++) begin
            idx = {word_sel, 2'(j)};
            if (idx < len_q)        byte_v = msg_buf[idx];
            else if (idx == len_q)  byte_v = 8'h80;
            else if (idx == 6'd62)  byte_v = {7'b0, bit_len[8]};
            else if (idx == 6'd63)  byte_v = bit_len[7:0];
            else                    byte_v = 8'h00;
            word_nxt[31-8*j -: 8] = byte_v;
        end
    end

    // Frame/collect/send FSM with registered word strobe, data and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            len_q       <= '0;
            byte_cnt    <= '0;
            word_cnt    <= '0;
            MP_dv_out   <= 1'b0;
            message_out <= '0;
            err_out     <= 1'b0;
            for (int i = 0; i < 64; i++) msg_buf[i] <= '0;
`ifdef RX_TIMEOUT_EN
            gap_cnt     <= '0;
`endif
        end else begin
            err_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_dv_in) begin
                        if (rx_byte_in > MAX_LEN_B) begin
                            err_out <= 1'b1;
                        end else begin
                            len_q    <= rx_byte_in[5:0];
                            byte_cnt <= '0;
                            state    <= (rx_byte_in == 8'd0) ? S_WAIT_CORE : S_COLLECT;
`ifdef RX_TIMEOUT_EN
                            gap_cnt  <= '0;
`endif
                        end
                    end
                end
                S_COLLECT: begin
                    if (rx_dv_in) begin
                        msg_buf[byte_cnt] <= rx_byte_in;
                        byte_cnt          <= byte_cnt + 6'd1;
                        if (byte_cnt + 6'd1 == len_q) state <= S_WAIT_CORE;
`ifdef RX_TIMEOUT_EN
                        gap_cnt <= '0;
                    end else if (gap_cnt == GAP_LAST) begin
                        // Sender went quiet: drop the partial frame.
                        err_out  <= 1'b1;
                        byte_cnt <= '0;
                        gap_cnt  <= '0;
                        state    <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
`endif
                    end
                end
                S_WAIT_CORE: begin
                    if (rx_dv_in) err_out <= 1'b1;
                    if (core_ready_in) begin
                        word_cnt    <= '0;
                        MP_dv_out   <= 1'b1;
                        message_out <= DATA_WIDTH'(word_nxt);
                        state       <= S_SEND;
                    end
                end
                S_SEND: begin
                    // Bytes arriving mid-block (including the last word cycle) are dropped.
                    if (rx_dv_in) err_out <= 1'b1;
                    if (word_cnt == 4'd15) begin
                        MP_dv_out   <= 1'b0;
                        message_out <= '0;
                        state       <= S_IDLE;
                    end else begin
                        word_cnt    <= word_cnt + 4'd1;
                        message_out <= DATA_WIDTH'(word_nxt);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_packer.sv
// Directed bench for sha256_msg_packer: framing, padding, latency, error
// pulses, reset abort and (when RX_TIMEOUT_EN is defined) the gap timeout.
module tb_sha256_msg_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_dv_in = 1'b0;
    logic [7:0]  rx_byte_in = '0;
    logic        core_ready_in = 1'b0;
    logic        MP_dv_out;
    logic [31:0] message_out;
    logic        busy_out;
    logic        err_out;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int err_cnt = 0;
    int first_dv = 0;
    int last_dv = 0;
    logic busy_seen = 1'b0;
    logic [31:0] words[$];

    sha256_msg_packer #(.DATA_WIDTH(32), .MAX_LEN(55), .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .rst(rst), .rx_dv_in(rx_dv_in), .rx_byte_in(rx_byte_in),
        .core_ready_in(core_ready_in), .MP_dv_out(MP_dv_out),
        .message_out(message_out), .busy_out(busy_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    // Cycle counter on the active edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (MP_dv_out) begin
            if (words.size() == 0) first_dv = cyc;
            last_dv = cyc;
            words.push_back(message_out);
        end
        if (err_out) err_cnt++;
        if (busy_out) busy_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte is sampled.
    task automatic send_byte(input logic [7:0] b);
        rx_byte_in = b;
        rx_dv_in   = 1'b1;
        @(posedge clk); #1;
        rx_dv_in   = 1'b0;
    endtask

    task automatic clear_mon();
        words.delete();
        err_cnt   = 0;
        busy_seen = 1'b0;
    endtask

    task automatic wait_words(input string tag, input int n);
        for (int i = 0; i < 100 && words.size() < n; i++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_nwords"}, words.size(), n);
    endtask

    logic [31:0] exp_w[16];

    task automatic chk_block(input string tag);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_w%0d", tag, i), (i < words.size()) ? words[i] : 32'hxxxxxxxx, exp_w[i]);
        chk({tag, "_span"}, last_dv - first_dv, 15);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dv", MP_dv_out, 0);
        chk("rst_msg", message_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_err", err_out, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // "abc" with the core ready
        clear_mon();
        core_ready_in = 1'b1;
        send_byte(8'h03); send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
        wait_words("abc", 16);
        foreach (exp_w[i]) exp_w[i] = 32'h0;
        exp_w[0] = 32'h61626380; exp_w[15] = 32'h00000018;
        chk_block("abc");
        chk("abc_err", err_cnt, 0);
        chk("abc_busy_end", busy_out, 0);

        // Empty message and its two-cycle launch latency
        clear_mon();
        send_byte(8'h00);
        @(negedge clk); chk("empty_lat1", MP_dv_out, 0);
        @(negedge clk); chk("empty_lat2", MP_dv_out, 1);
        @(posedge clk); #1;
        wait_words("empty", 16);
        foreach (exp_w[i]) exp_w[i] = 32'h0;
        exp_w[0] = 32'h80000000;
        chk_block("empty");

        // Maximum length 55 bytes 0x01..0x37
        clear_mon();
        send_byte(8'h37);
        for (int i = 1; i <= 55; i++) send_byte(8'(i));
        wait_words("max", 16);
        foreach (exp_w[i]) exp_w[i] = {8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 8'(4*i+4)};
        exp_w[13] = 32'h35363780; exp_w[14] = 32'h0; exp_w[15] = 32'h000001B8;
        chk_block("max");
        chk("max_err", err_cnt, 0);

        // Oversize length byte rejected
        clear_mon();
        send_byte(8'h38);
        repeat (4) @(posedge clk);
        #1;
        chk("big_err", err_cnt, 1);
        chk("big_busy", busy_seen, 0);
        chk("big_nwords", words.size(), 0);

        // Core not ready for 50 cycles, stray byte while waiting
        clear_mon();
        core_ready_in = 1'b0;
        send_byte(8'h03); send_byte(8'h78); send_byte(8'h79); send_byte(8'h7a);
        repeat (20) @(posedge clk);
        #1;
        send_byte(8'hAA);
        repeat (29) @(posedge clk);
        #1;
        chk("wait_nwords", words.size(), 0);
        chk("wait_busy", busy_out, 1);
        chk("wait_err", err_cnt, 1);
        core_ready_in = 1'b1;
        wait_words("wait", 16);
        foreach (exp_w[i]) exp_w[i] = 32'h0;
        exp_w[0] = 32'h78797a80; exp_w[15] = 32'h00000018;
        chk_block("wait");
        chk("wait_err_end", err_cnt, 1);

        // Reset on the 5th word cycle aborts the block
        clear_mon();
        send_byte(8'h00);
        n = 0;
        for (int i = 0; i < 20 && n < 5; i++) begin
            @(posedge clk); #1;
            if (MP_dv_out) n++;
        end
        chk("abort_reach5", n, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_dv", MP_dv_out, 0);
        chk("abort_busy", busy_out, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("abort_nwords", words.size(), 5);

`ifdef RX_TIMEOUT_EN
        // Partial frame times out, next frame is clean
        clear_mon();
        send_byte(8'h05); send_byte(8'h01); send_byte(8'h02);
        for (int i = 0; i < 40 && err_cnt == 0; i++) begin
            @(posedge clk); #1;
        end
        chk("tmo_err", err_cnt, 1);
        chk("tmo_busy", busy_out, 0);
        clear_mon();
        send_byte(8'h01); send_byte(8'h41);
        wait_words("tmo", 16);
        foreach (exp_w[i]) exp_w[i] = 32'h0;
        exp_w[0] = 32'h41800000; exp_w[15] = 32'h00000008;
        chk_block("tmo");
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sha256_msg_packer.md
Name: sha256_msg_packer

Overview:
- Front end of the SHA-256 datapath: takes the UART receiver byte stream and frames, pads and packs one single-block message into sixteen 32-bit big-endian words.
- Drives them into the SHA-256 core word interface (`MP_dv` / `message`), one word per cycle.
- It is the producer end of the link the core consumes. The UART transmitter sits on the core's output side.
- Frame format: one length byte L (0..55), then L message bytes.

Parameters:
- DATA_WIDTH, 32, output word width; only 32 is supported.
- MAX_LEN, 55, largest message length in bytes that fits one 512-bit block with padding.
- TIMEOUT_CYCLES, 100000, inter-byte idle limit; used only with RX_TIMEOUT_EN.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset.
- rx_dv_in  input  1  one-cycle strobe from the UART receiver; rx_byte_in is valid.
- rx_byte_in  input  8  received byte.
- core_ready_in  input  1  high when the SHA-256 core is idle and can accept a block.
- MP_dv_out  output  1  word strobe to the core; high for exactly 16 consecutive cycles per block.
- message_out  output  DATA_WIDTH  packed word, valid while MP_dv_out is high.
- busy_out  output  1  high in every state except S_IDLE.
- err_out  output  1  one-cycle error pulse.

Behaviour:
- Reset:
  - Synchronous, active-high, single clock domain (clk, rst); rst is sampled on the rising clk edge.
  - On reset: state=S_IDLE, all counters 0, byte buffer cleared.
  - Output reset values: MP_dv_out=0, message_out=0, busy_out=0, err_out=0.
  - Reset asserted in any state, including mid-S_SEND, aborts immediately. No further MP_dv_out pulses.
- State S_IDLE:
  - On rx_dv_in, latch L=rx_byte_in.
  - L>MAX_LEN: pulse err_out next cycle, remain in S_IDLE.
  - L==0: go to S_WAIT_CORE.
  - Otherwise clear byte_cnt and go to S_COLLECT.
- State S_COLLECT:
  - Each rx_dv_in stores rx_byte_in into buf[byte_cnt] and increments byte_cnt (6 bits).
  - When the stored byte makes byte_cnt==L, go to S_WAIT_CORE.
  - No other exit except reset or timeout.
- State S_WAIT_CORE:
  - Wait for core_ready_in=1, then clear word_cnt and enter S_SEND on the next edge.
  - Holds indefinitely while core_ready_in=0.
- State S_SEND:
  - MP_dv_out=1 on 16 consecutive cycles, word_cnt 0..15, with message_out=W[word_cnt].
  - After word 15, go to S_IDLE. MP_dv_out deasserts on the cycle after word 15.
  - core_ready_in is ignored once S_SEND is entered.
- Word construction (registered output; MP_dv_out and message_out change on the same edge):
  - Byte index idx=4*word_cnt+j, j=0..3, j=0 is the most significant byte.
  - idx<L: buf[idx].
  - idx==L: 0x80.
  - L<idx<56: 0x00.
  - 56..63: 64-bit big-endian bit length L*8. Only bytes 62 and 63 can be nonzero (max 440 = 0x1B8).
- Latency:
  - Length byte to first MP_dv_out with L=0 and core_ready_in=1: 2 cycles.
  - Last message byte to first MP_dv_out with core_ready_in=1: 2 cycles.
- Boundary conditions:
  - rx_dv_in in S_WAIT_CORE or S_SEND: byte dropped, err_out pulses next cycle, state unaffected.
  - rx_dv_in on the same cycle as the S_SEND->S_IDLE transition: dropped with err_out. The packer is not yet in S_IDLE.
  - err_out pulses from two sources on the same cycle merge into one pulse.

Optional Feature:
- Macro RX_TIMEOUT_EN.
- Defined:
  - A gap counter runs in S_COLLECT, cleared on every rx_dv_in.
  - Reaching TIMEOUT_CYCLES discards the partial frame, pulses err_out and returns to S_IDLE; byte_cnt is cleared.
- Undefined:
  - No counter is present; S_COLLECT waits forever for bytes.

Test Plan:
- Frame 0x03,'a','b','c', core_ready_in=1 -> 16 back-to-back words: 0x61626380, then 13x 0x00000000, then 0x00000000, 0x00000018; err_out never pulses.
- Frame 0x00 -> words 0x80000000, then 14x 0x00000000, then 0x00000000; first MP_dv_out 2 cycles after the length strobe.
- Frame 0x37 with bytes 0x01..0x37 -> word13=0x35363780, word14=0x00000000, word15=0x000001B8.
- Length byte 0x38 -> one err_out pulse, busy_out stays 0, no MP_dv_out.
- core_ready_in held 0 for 50 cycles after a 3-byte frame, plus an extra rx_dv_in during the wait -> no MP_dv_out until ready rises, one err_out pulse, output words unchanged.
- rst=1 on the 5th MP_dv_out cycle -> MP_dv_out=0 on the following cycle, busy_out=0. With RX_TIMEOUT_EN and TIMEOUT_CYCLES=20: frame 0x05 plus 2 bytes then silence -> err_out pulses after 20 idle cycles, and the next frame 0x01,0x41 yields word0=0x41800000.
